// File: rtl/fft_seq_pkg.sv
// Shared types and index helpers for the FFT twiddle sequencer.
// Helpers work at IDX_W bits; callers cut the result to their own width.
package fft_seq_pkg;

  localparam int N_LOG2_DEF = 5;
  localparam int IDX_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [IDX_W-1:0] tw_base(
    input logic [2:0] s
  );
    return (IDX_W'(1) << s) - IDX_W'(1);
  endfunction

  // returns {b, a}
  function automatic logic [2*IDX_W-1:0] bf_indices(
    input logic [2:0]       s,
    input logic [IDX_W-1:0] j
  );
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    k = j & tw_base(s);
    g = j >> s;
    a = (g << ({1'b0, s} + 4'd1)) | k;
    b = a + (IDX_W'(1) << s);
    return {b, a};
  endfunction

endpackage

// File: rtl/fft_tag_delay.sv
// Register line that carries butterfly tags alongside the twiddle ROM read.
// Depth equals the ROM read latency; clr empties it synchronously.
module fft_tag_delay #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] line [LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LAT; i++) line[i] <= '0;
    end else begin
      line[0] <= din;
      for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
    end
  end

  assign dout = line[LAT-1];

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT stage/butterfly scheduler: drives twiddle ROM address and
// emits operand indices and tags aligned with the ROM read data.
module fft_twiddle_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N_LOG2    = N_LOG2_DEF,
  parameter int ROM_LAT   = 1,
  parameter int STAGE_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] tw_addr,
  output logic              bf_valid,
  output logic [N_LOG2-1:0] bf_idx_a,
  output logic [N_LOG2-1:0] bf_idx_b,
  output logic [2:0]        bf_stage,
  output logic              bf_last
);

  localparam int JW = N_LOG2 - 1;
  localparam int TW = 2 * N_LOG2 + 5;
  localparam logic [JW-1:0] J_MAX = '1;
  localparam logic [2:0]    S_MAX = 3'(N_LOG2 - 1);

  state_t state;
  state_t state_nxt;

  logic [2:0]        s;
  logic [2:0]        s_nxt;
  logic [JW-1:0]     j;
  logic [JW-1:0]     j_nxt;
  logic [3:0]        gap_cnt;
  logic [3:0]        gap_nxt;
  logic [N_LOG2-1:0] tw_q;
  logic [N_LOG2-1:0] tw_nxt;
  logic [TW-1:0]     iss;
  logic [TW-1:0]     iss_nxt;
  logic [TW-1:0]     dly;

  logic [N_LOG2-1:0] a_c;
  logic [N_LOG2-1:0] b_c;
  logic [N_LOG2-1:0] tw_c;
  logic              stage_end;
  logic              final_bf;
  logic              issue;
  logic              dly_valid;
  logic              dly_last;

  assign a_c  = N_LOG2'(bf_indices(s, IDX_W'(j)));
  assign b_c  = N_LOG2'(bf_indices(s, IDX_W'(j)) >> IDX_W);
  assign tw_c = N_LOG2'(tw_base(s) + (IDX_W'(j) & tw_base(s)));

  assign stage_end = (j == J_MAX);
  assign final_bf  = stage_end && (s == S_MAX);

  // the start edge itself issues butterfly 0
  assign issue = ((state == IDLE) && start) ||
                 ((state == RUN) && !hold);

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    j_nxt     = j;
    gap_nxt   = gap_cnt;
    tw_nxt    = tw_q;
    iss_nxt   = '0;
    if (issue) begin
      tw_nxt  = tw_c;
      iss_nxt = {1'b1, a_c, b_c, s, final_bf};
      if (final_bf) begin
        j_nxt     = '0;
        s_nxt     = '0;
        state_nxt = DRAIN;
      end else if (stage_end) begin
        j_nxt     = '0;
        s_nxt     = s + 3'd1;
        gap_nxt   = '0;
        state_nxt = (STAGE_GAP > 0) ? GAP : RUN;
      end else begin
        j_nxt     = j + 1'b1;
        state_nxt = RUN;
      end
    end
    unique case (state)
      GAP: begin
        gap_nxt = gap_cnt + 4'd1;
        if (gap_nxt == 4'(STAGE_GAP)) state_nxt = RUN;
      end
      DRAIN: begin
        if (dly_valid && dly_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      j       <= '0;
      gap_cnt <= '0;
      tw_q    <= '0;
      iss     <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      j       <= j_nxt;
      gap_cnt <= gap_nxt;
      tw_q    <= tw_nxt;
      iss     <= iss_nxt;
    end
  end

  fft_tag_delay #(
    .W   (TW),
    .LAT (ROM_LAT)
  ) u_dly (
    .clk  (clk),
    .clr  (rst),
    .din  (iss),
    .dout (dly)
  );

  assign dly_valid = dly[TW-1];
  assign dly_last  = dly[0];

  assign {bf_valid, bf_idx_a, bf_idx_b, bf_stage, bf_last} = dly;

  assign tw_addr = tw_q;
  assign busy    = (state == RUN) || (state == GAP) ||
                   (state == DRAIN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: N=32, ROM_LAT=1,
// one instance with no stage gap and one with a 2-cycle gap.
module tb_fft_twiddle_sequencer;

  localparam int NB = 80;
  localparam int NC = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic start0 = 1'b0;
  logic hold0  = 1'b0;
  logic start2 = 1'b0;
  logic hold2  = 1'b0;

  logic       busy0, done0, v0, l0;
  logic [4:0] tw0, a0, b0;
  logic [2:0] st0;
  logic       busy2, done2, v2, l2;
  logic [4:0] tw2, a2, b2;
  logic [2:0] st2;

  fft_twiddle_sequencer #(
    .N_LOG2(5), .ROM_LAT(1), .STAGE_GAP(0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .hold(hold0),
    .busy(busy0), .done(done0), .tw_addr(tw0),
    .bf_valid(v0), .bf_idx_a(a0), .bf_idx_b(b0),
    .bf_stage(st0), .bf_last(l0)
  );

  fft_twiddle_sequencer #(
    .N_LOG2(5), .ROM_LAT(1), .STAGE_GAP(2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .hold(hold2),
    .busy(busy2), .done(done2), .tw_addr(tw2),
    .bf_valid(v2), .bf_idx_a(a2), .bf_idx_b(b2),
    .bf_stage(st2), .bf_last(l2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cur_cyc = 0;

  int exp_v[NC], exp_a[NC], exp_b[NC], exp_st[NC], exp_l[NC];
  int exp_tw[NC], exp_busy[NC], exp_done[NC];
  int obs_v[NC], obs_a[NC], obs_b[NC], obs_st[NC], obs_l[NC];
  int obs_tw[NC], obs_done[NC];
  int seen[5][32];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cur_cyc, got, exp);
    end
  endtask

  // independent index formula: divide/modulo rather than shift/mask
  function automatic void beat(input int n, output int a,
                               output int b, output int s,
                               output int tw);
    int j, half;
    s    = n / 16;
    j    = n % 16;
    half = 1 << s;
    a    = (j / half) * 2 * half + (j % half);
    b    = a + half;
    tw   = half - 1 + (j % half);
  endfunction

  task automatic build_exp(input int g, input int hf,
                           input int hl, input int rst_at);
    int ic[NB];
    int tw_at[NC];
    int n, gl, cur, a, b, s, tw, lastv, dc;
    for (int c = 0; c < NC; c++) begin
      exp_v[c] = 0; exp_a[c] = 0; exp_b[c] = 0;
      exp_st[c] = 0; exp_l[c] = 0; tw_at[c] = -1;
    end
    ic[0] = 1;
    n = 1;
    gl = 0;
    for (int e = 1; n < NB && e < NC; e++) begin
      if (gl > 0) gl--;
      else if (!(e >= hf && e < hf + hl)) begin
        ic[n] = e + 1;
        if (n % 16 == 15) gl = g;
        n++;
      end
    end
    for (int k = 0; k < NB; k++) begin
      beat(k, a, b, s, tw);
      tw_at[ic[k]] = tw;
      exp_v[ic[k]+1]  = 1;
      exp_a[ic[k]+1]  = a;
      exp_b[ic[k]+1]  = b;
      exp_st[ic[k]+1] = s;
      exp_l[ic[k]+1]  = (k == NB - 1) ? 1 : 0;
    end
    lastv = ic[NB-1] + 1;
    dc = lastv + 1;
    cur = 0;
    for (int c = 1; c < NC; c++) begin
      if (tw_at[c] >= 0) cur = tw_at[c];
      exp_tw[c]   = cur;
      exp_busy[c] = (c <= lastv) ? 1 : 0;
      exp_done[c] = (c == dc) ? 1 : 0;
      if (rst_at > 0 && c > rst_at) begin
        exp_v[c] = 0; exp_tw[c] = 0;
        exp_busy[c] = 0; exp_done[c] = 0;
      end
    end
  endtask

  task automatic run(input bit g, input int hf, input int hl,
                     input int ra, input int rb,
                     input int rst_at, input int ncyc,
                     input bit sb);
    build_exp(g ? 2 : 0, hf, hl, rst_at);
    for (int c = 0; c < NC; c++) begin
      obs_v[c] = 0; obs_a[c] = 0; obs_b[c] = 0; obs_st[c] = 0;
      obs_l[c] = 0; obs_tw[c] = 0; obs_done[c] = 0;
    end
    for (int s = 0; s < 5; s++)
      for (int i = 0; i < 32; i++) seen[s][i] = 0;
    @(negedge clk);
    if (g) start2 = 1'b1;
    else   start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      hold0 = 1'b0; hold2 = 1'b0; rst = 1'b0;
      cur_cyc = c;
      obs_v[c]    = int'(g ? v2 : v0);
      obs_a[c]    = int'(g ? a2 : a0);
      obs_b[c]    = int'(g ? b2 : b0);
      obs_st[c]   = int'(g ? st2 : st0);
      obs_l[c]    = int'(g ? l2 : l0);
      obs_tw[c]   = int'(g ? tw2 : tw0);
      obs_done[c] = int'(g ? done2 : done0);
      chk("valid", 32'(obs_v[c]), 32'(exp_v[c]));
      chk("busy", 32'(g ? busy2 : busy0), 32'(exp_busy[c]));
      chk("done", 32'(obs_done[c]), 32'(exp_done[c]));
      chk("tw_addr", 32'(obs_tw[c]), 32'(exp_tw[c]));
      if (exp_v[c] == 1) begin
        chk("idx_a", 32'(obs_a[c]), 32'(exp_a[c]));
        chk("idx_b", 32'(obs_b[c]), 32'(exp_b[c]));
        chk("stage", 32'(obs_st[c]), 32'(exp_st[c]));
        chk("last", 32'(obs_l[c]), 32'(exp_l[c]));
      end
      if (obs_v[c] == 1) begin
        chk("b_minus_a", 32'(obs_b[c] - obs_a[c]),
            32'(1 << obs_st[c]));
        if (obs_st[c] < 5) begin
          seen[obs_st[c]][obs_a[c]]++;
          seen[obs_st[c]][obs_b[c]]++;
        end
      end
      if (c >= hf && c < hf + hl) begin
        if (g) hold2 = 1'b1;
        else   hold0 = 1'b1;
      end
      if (c == ra || c == rb) begin
        if (g) start2 = 1'b1;
        else   start0 = 1'b1;
      end
      if (c == rst_at) rst = 1'b1;
    end
    if (sb) begin
      cur_cyc = 0;
      for (int s = 0; s < 5; s++)
        for (int i = 0; i < 32; i++)
          chk("sb_once", 32'(seen[s][i]), 32'd1);
    end
  endtask

  function automatic int first_done();
    for (int c = 1; c < NC; c++)
      if (obs_done[c] == 1) return c;
    return -1;
  endfunction

  function automatic int count_done();
    int n = 0;
    for (int c = 1; c < NC; c++) n += obs_done[c];
    return n;
  endfunction

  function automatic int count_valid();
    int n = 0;
    for (int c = 1; c < NC; c++) n += obs_v[c];
    return n;
  endfunction

  function automatic int count_last();
    int n = 0;
    for (int c = 1; c < NC; c++) n += obs_l[c] & obs_v[c];
    return n;
  endfunction

  function automatic int bubbles();
    int f = -1, l = -1, n = 0;
    for (int c = 1; c < NC; c++)
      if (obs_v[c] == 1) begin
        if (f < 0) f = c;
        l = c;
      end
    if (f < 0) return -1;
    for (int c = f; c <= l; c++)
      if (obs_v[c] == 0) n++;
    return n;
  endfunction

  int fnd;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_tw", 32'(tw0), 32'd0);
    chk("rst_valid_g", 32'(v2), 32'd0);
    chk("rst_busy_g", 32'(busy2), 32'd0);
    rst = 1'b0;

    run(1'b0, 0, 0, 0, 0, 0, 95, 1'b1);
    cur_cyc = 0;
    chk("t1_done_cyc", 32'(first_done()), 32'd82);
    chk("t1_done_cnt", 32'(count_done()), 32'd1);
    chk("t1_beats", 32'(count_valid()), 32'd80);
    chk("t1_last_cnt", 32'(count_last()), 32'd1);
    fnd = 0;
    for (int c = 2; c < NC; c++)
      if (obs_v[c] == 1 && obs_st[c] == 2 && obs_a[c] == 9) fnd = c;
    chk("t2_found", 32'(fnd > 0), 32'd1);
    if (fnd > 0) begin
      chk("t2_b", 32'(obs_b[fnd]), 32'd13);
      chk("t2_tw", 32'(obs_tw[fnd-1]), 32'd4);
    end
    fnd = 0;
    for (int c = 2; c < NC; c++)
      if (obs_v[c] == 1 && obs_l[c] == 1) fnd = c;
    chk("t3_last_cyc", 32'(fnd), 32'd81);
    if (fnd > 0) begin
      chk("t3_a", 32'(obs_a[fnd]), 32'd15);
      chk("t3_b", 32'(obs_b[fnd]), 32'd31);
      chk("t3_stage", 32'(obs_st[fnd]), 32'd4);
      chk("t3_tw", 32'(obs_tw[fnd-1]), 32'd30);
    end

    run(1'b1, 0, 0, 0, 0, 0, 100, 1'b1);
    cur_cyc = 0;
    chk("t4_done_cyc", 32'(first_done()), 32'd90);
    chk("t4_beats", 32'(count_valid()), 32'd80);
    chk("t4_bubbles", 32'(bubbles()), 32'd8);

    run(1'b0, 20, 3, 0, 0, 0, 100, 1'b1);
    cur_cyc = 0;
    chk("t5_done_cyc", 32'(first_done()), 32'd85);
    chk("t5_beats", 32'(count_valid()), 32'd80);
    chk("t5_bubbles", 32'(bubbles()), 32'd3);

    run(1'b0, 0, 0, 30, 82, 0, 100, 1'b1);
    cur_cyc = 0;
    chk("t6_done_cyc", 32'(first_done()), 32'd82);
    chk("t6_done_cnt", 32'(count_done()), 32'd1);
    chk("t6_beats", 32'(count_valid()), 32'd80);

    run(1'b0, 0, 0, 0, 0, 40, 60, 1'b0);
    cur_cyc = 0;
    chk("t7_done_cnt", 32'(count_done()), 32'd0);
    chk("t7_beats", 32'(count_valid()), 32'd39);

    run(1'b0, 0, 0, 0, 0, 0, 90, 1'b1);
    cur_cyc = 0;
    chk("t7_re_a", 32'(obs_a[2]), 32'd0);
    chk("t7_re_b", 32'(obs_b[2]), 32'd1);
    chk("t7_re_tw", 32'(obs_tw[1]), 32'd0);
    chk("t7_re_done", 32'(first_done()), 32'd82);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
